// File: rtl/tlp_txrd_tag.sv
// Memory-read TLP request tagger: allocates read tags from a 32-entry pool and
// formats the 3DW/4DW MRd header; tags are returned when the final completion lands.
module tlp_txrd_tag #(
    parameter int unsigned C_TAG_NUM = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [15:0]  i_cfg_requester_id,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [63:0]  i_req_addr,
    input  logic [9:0]   i_req_len,
    output logic [4:0]   o_req_tag,
    output logic         o_hdr_valid,
    input  logic         i_hdr_ready,
    output logic [127:0] o_hdr_data,
    output logic         o_hdr_4dw,
    input  logic         i_cpl_done_valid,
    input  logic [4:0]   i_cpl_done_tag,
    output logic [5:0]   o_tags_free,
    output logic         o_err_release
);

    typedef enum logic [0:0] {StIdle, StHdr} state_e;

    state_e                 r_state;
    logic [C_TAG_NUM-1:0]   r_busy;
    logic                   r_hdr_valid;
    logic [127:0]           r_hdr_data;
    logic                   r_hdr_4dw;
    logic                   r_err_release;
    logic [5:0]             r_tags_free;

    logic                   w_any_free;
    logic [4:0]             w_free_tag;
    logic                   w_accept;
    logic                   w_rel_ok;
    logic                   w_rel_err;
    logic [C_TAG_NUM-1:0]   w_busy_d;
    logic [5:0]             w_busy_cnt;
    logic                   w_4dw;
    logic [3:0]             w_last_be;
    logic [31:0]            w_dw0;
    logic [31:0]            w_dw1;
    logic [31:0]            w_addr_lo;
    logic [127:0]           w_hdr;
    logic                   w_unused_addr;

    // Lowest-numbered free tag wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_free_tag = '0;
        w_any_free = 1'b0;
        for (int i = C_TAG_NUM - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_tag = 5'(i);
                w_any_free = 1'b1;
            end
        end
    end

    assign o_req_ready = (r_state == StIdle) && w_any_free && !i_rst;
    assign o_req_tag   = w_free_tag;
    assign w_accept    = i_req_valid && o_req_ready;

    assign w_rel_ok  = i_cpl_done_valid && r_busy[i_cpl_done_tag];
    assign w_rel_err = i_cpl_done_valid && !r_busy[i_cpl_done_tag];

    // Allocate and release never hit the same bit: a just-allocated tag was free.
    always_comb begin
        w_busy_d = r_busy;
        if (w_accept) begin
            w_busy_d[w_free_tag] = 1'b1;
        end
        if (w_rel_ok) begin
            w_busy_d[i_cpl_done_tag] = 1'b0;
        end
    end

    always_comb begin
        w_busy_cnt = '0;
        for (int i = 0; i < C_TAG_NUM; i++) begin
            w_busy_cnt = w_busy_cnt + 6'(w_busy_d[i]);
        end
    end

    assign w_4dw         = |i_req_addr[63:32];
    assign w_last_be     = (i_req_len == 10'd1) ? 4'h0 : 4'hF;
    assign w_addr_lo     = {i_req_addr[31:2], 2'b00};
    assign w_unused_addr = ^i_req_addr[1:0];
    assign w_dw0         = {2'b00, w_4dw, 5'b00000, 14'd0, i_req_len};
    assign w_dw1         = {i_cfg_requester_id, 3'b000, w_free_tag, w_last_be, 4'hF};
    assign w_hdr         = w_4dw ? {w_addr_lo, i_req_addr[63:32], w_dw1, w_dw0}
                                 : {32'd0, w_addr_lo, w_dw1, w_dw0};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_busy        <= '0;
            r_hdr_valid   <= 1'b0;
            r_hdr_data    <= '0;
            r_hdr_4dw     <= 1'b0;
            r_err_release <= 1'b0;
            r_tags_free   <= 6'(C_TAG_NUM);
        end else begin
            r_busy        <= w_busy_d;
            r_tags_free   <= 6'(C_TAG_NUM) - w_busy_cnt;
            r_err_release <= w_rel_err;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state     <= StHdr;
                        r_hdr_valid <= 1'b1;
                        r_hdr_data  <= w_hdr;
                        r_hdr_4dw   <= w_4dw;
                    end
                end
                StHdr: begin
                    if (i_hdr_ready) begin
                        r_state     <= StIdle;
                        r_hdr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_hdr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_hdr_valid   = r_hdr_valid;
    assign o_hdr_data    = r_hdr_data;
    assign o_hdr_4dw     = r_hdr_4dw;
    assign o_err_release = r_err_release;
    assign o_tags_free   = r_tags_free;

endmodule

// File: tb/tb_tlp_txrd_tag.sv
// Bench for tlp_txrd_tag: directed requests/releases; expected headers are queued
// by the stimulus and checked by a separate monitor when a header is accepted.
module tb_tlp_txrd_tag;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  cfg_requester_id;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_addr;
    logic [9:0]   req_len;
    logic [4:0]   req_tag;
    logic         hdr_valid;
    logic         hdr_ready;
    logic [127:0] hdr_data;
    logic         hdr_4dw;
    logic         cpl_done_valid;
    logic [4:0]   cpl_done_tag;
    logic [5:0]   tags_free;
    logic         err_release;

    int n_cmp = 0;
    int n_bad = 0;
    logic [128:0] exp_q[$];

    tlp_txrd_tag #(.C_TAG_NUM(32)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_cfg_requester_id (cfg_requester_id),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_addr         (req_addr),
        .i_req_len          (req_len),
        .o_req_tag          (req_tag),
        .o_hdr_valid        (hdr_valid),
        .i_hdr_ready        (hdr_ready),
        .o_hdr_data         (hdr_data),
        .o_hdr_4dw          (hdr_4dw),
        .i_cpl_done_valid   (cpl_done_valid),
        .i_cpl_done_tag     (cpl_done_tag),
        .o_tags_free        (tags_free),
        .o_err_release      (err_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Independent header model: {4dw, DW3, DW2, DW1, DW0}.
    function automatic logic [128:0] mk_hdr(input logic [63:0] a, input logic [9:0] l,
                                            input logic [15:0] id, input logic [4:0] t);
        logic        is4;
        logic [31:0] d0, d1, d2, d3;
        is4 = (a[63:32] != 32'd0);
        d0  = {3'b000, 29'd0} | (is4 ? 32'h2000_0000 : 32'd0) | {22'd0, l};
        d1  = {id, 3'b000, t, ((l == 10'd1) ? 4'h0 : 4'hF), 4'hF};
        if (is4) begin
            d2 = a[63:32];
            d3 = {a[31:2], 2'b00};
        end else begin
            d2 = {a[31:2], 2'b00};
            d3 = 32'd0;
        end
        return {is4, d3, d2, d1, d0};
    endfunction

    always @(negedge clk) begin
        if (hdr_valid && hdr_ready) begin
            if (exp_q.size() == 0) begin
                chk("hdr_unexpected", 128'(hdr_valid), 128'd0);
            end else begin
                logic [128:0] e;
                e = exp_q.pop_front();
                chk("hdr_data", hdr_data, e[127:0]);
                chk("hdr_4dw", 128'(hdr_4dw), 128'(e[128]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a request, wait (bounded) for ready, check tag, queue expected header.
    task automatic do_req(input logic [63:0] a, input logic [9:0] l, input logic [15:0] id,
                          input logic [4:0] etag, input logic [128:0] eh);
        int k;
        k = 0;
        req_addr         = a;
        req_len          = l;
        cfg_requester_id = id;
        req_valid        = 1'b1;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 128'(req_ready), 128'd1);
        end else begin
            chk("req_tag", 128'(req_tag), 128'(etag));
            exp_q.push_back(eh);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic release_tag(input logic [4:0] t);
        cpl_done_valid = 1'b1;
        cpl_done_tag   = t;
        tick();
        cpl_done_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        rst = 1'b1; req_valid = 1'b0; hdr_ready = 1'b1; cpl_done_valid = 1'b0;
        cpl_done_tag = '0; req_addr = '0; req_len = '0; cfg_requester_id = '0;
        tick();
        @(negedge clk);
        chk("ready_in_reset", 128'(req_ready), 128'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tags_free", 128'(tags_free), 128'd32);
        chk("rst_hdr_valid", 128'(hdr_valid), 128'd0);
        chk("rst_err", 128'(err_release), 128'd0);
        chk("rst_hdr_data", hdr_data, 128'd0);
        tick();

        // 3DW, len 1
        do_req(64'h0000_0000_1000_0040, 10'd1, 16'h0100, 5'd0,
               {1'b0, 32'h0000_0000, 32'h1000_0040, 32'h0100_000F, 32'h0000_0001});
        @(negedge clk);
        chk("hdr_valid_after_hs", 128'(hdr_valid), 128'd1);
        chk("ready_in_hdr", 128'(req_ready), 128'd0);
        chk("free_after_1", 128'(tags_free), 128'd31);
        tick();

        // 4DW, len 0 (1024 DW)
        do_req(64'h0000_0001_0000_0000, 10'd0, 16'h0100, 5'd1,
               {1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0100_01FF, 32'h2000_0000});
        release_tag(5'd0);
        release_tag(5'd1);
        @(negedge clk);
        chk("free_after_rel", 128'(tags_free), 128'd32);
        chk("err_after_good_rel", 128'(err_release), 128'd0);
        tick();

        // Fill the pool with hdr_ready held high
        for (int i = 0; i < 32; i++) begin
            a = 64'h0000_0000_2000_0003 | (64'(i) << 6) | ((i % 2 == 1) ? 64'h3_0000_0000 : 64'd0);
            do_req(a, 10'(i), 16'hBEEF, 5'(i), mk_hdr(a, 10'(i), 16'hBEEF, 5'(i)));
        end
        tick();
        tick();
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_ready", 128'(req_ready), 128'd0);
            chk("full_no_hdr", 128'(hdr_valid), 128'd0);
        end
        chk("full_tags_free", 128'(tags_free), 128'd0);
        tick();
        // Release 7 while a request waits: not allocatable in the release cycle
        cpl_done_valid = 1'b1;
        cpl_done_tag   = 5'd7;
        @(negedge clk);
        chk("no_rel_bypass", 128'(req_ready), 128'd0);
        tick();
        cpl_done_valid = 1'b0;
        a = 64'h0000_0000_0000_7000;
        do_req(a, 10'd8, 16'h0100, 5'd7, mk_hdr(a, 10'd8, 16'h0100, 5'd7));
        tick();
        tick();

        // Simultaneous release of 2 and allocation of 5
        release_tag(5'd5);
        req_addr = 64'h0000_0000_0000_5000; req_len = 10'd2; cfg_requester_id = 16'h0100;
        req_valid = 1'b1; cpl_done_valid = 1'b1; cpl_done_tag = 5'd2;
        @(negedge clk);
        chk("sim_ready", 128'(req_ready), 128'd1);
        chk("sim_tag", 128'(req_tag), 128'd5);
        exp_q.push_back({1'b0, 32'h0000_0000, 32'h0000_5000, 32'h0100_05FF, 32'h0000_0002});
        tick();
        req_valid = 1'b0; cpl_done_valid = 1'b0;
        @(negedge clk);
        chk("sim_free", 128'(tags_free), 128'd1);
        tick();

        // Release of a free tag
        release_tag(5'd3);
        release_tag(5'd3);
        @(negedge clk);
        chk("err_pulse", 128'(err_release), 128'd1);
        chk("err_free_unchanged", 128'(tags_free), 128'd2);
        tick();
        @(negedge clk);
        chk("err_one_cycle", 128'(err_release), 128'd0);
        tick();

        // Header stall then reset during HDR
        hdr_ready = 1'b0;
        do_req(64'h0000_0000_8000_1237, 10'd4, 16'h1234, 5'd2,
               {1'b0, 32'h0000_0000, 32'h8000_1234, 32'h1234_02FF, 32'h0000_0004});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 128'(hdr_valid), 128'd1);
            chk("stall_data", hdr_data,
                {32'h0000_0000, 32'h8000_1234, 32'h1234_02FF, 32'h0000_0004});
            chk("stall_ready", 128'(req_ready), 128'd0);
        end
        tick();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("ready_in_reset2", 128'(req_ready), 128'd0);
        tick();
        rst = 1'b0;
        hdr_ready = 1'b1;
        @(negedge clk);
        chk("rst_hdr_valid2", 128'(hdr_valid), 128'd0);
        chk("rst_tags_free2", 128'(tags_free), 128'd32);
        tick();

        do_req(64'h0000_0000_0000_0040, 10'd1023, 16'hFFFF, 5'd0,
               {1'b0, 32'h0000_0000, 32'h0000_0040, 32'hFFFF_00FF, 32'h0000_03FF});
        tick();
        tick();
        chk("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tlp_txrd_tag.md
TLP_TXRD_TAG -- requirements
Module: tlp_txrd_tag

Interface
REQ-001 Parameter C_TAG_NUM, default 32: number of read tags in the pool, fixed at 32 in this revision; tag width 5.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cfg_requester_id  in  16  bus/dev/func placed in every header.
REQ-005 req_valid  in  1  read request offered.
REQ-006 req_ready  out  1  request accepted when req_valid&req_ready.
REQ-007 req_addr  in  64  byte address, bits [1:0] ignored and treated as 0.
REQ-008 req_len  in  10  length in DW; 0 encodes 1024.
REQ-009 req_tag  out  5  tag assigned, valid in the handshake cycle.
REQ-010 hdr_valid  out  1  MRd header available.
REQ-011 hdr_ready  in  1  downstream TX arbiter accepts header.
REQ-012 hdr_data  out  128  DW0 [31:0], DW1 [63:32], DW2 [95:64], DW3 [127:96].
REQ-013 hdr_4dw  out  1  1 = 4DW header, 0 = 3DW header.
REQ-014 cpl_done_valid  in  1  final completion for a tag received (from RX completion buffer).
REQ-015 cpl_done_tag  in  5  tag to release.
REQ-016 tags_free  out  6  count of free tags, 0..32.
REQ-017 err_release  out  1  one-cycle pulse on release of a tag that is not in use.

Function
REQ-018 Tag pool: 32-bit busy bitmap; 1 = outstanding.
REQ-019 FSM states IDLE and HDR; IDLE->HDR on request handshake; HDR->IDLE on hdr_valid&hdr_ready.
REQ-020 req_ready = 1 only in IDLE with at least one busy bit clear, evaluated on the registered bitmap.
REQ-021 Allocation: lowest-numbered free tag; req_tag combinationally reflects it whenever req_ready = 1.
REQ-022 On handshake: latch addr/len/tag, set busy bit in the same edge.
REQ-023 hdr_valid = 1 exactly while in HDR; first asserted the cycle after the handshake; hdr_data/hdr_4dw stable until accepted.
REQ-024 Back-to-back throughput: one request per 2 cycles when hdr_ready is held 1.
REQ-025 hdr_4dw = 1 iff latched addr[63:32] != 0.
REQ-026 DW0: [31:29] fmt = 000 (3DW) or 001 (4DW); [28:24] type = 00000; TC, TD, EP, attr = 0; [9:0] = req_len.
REQ-027 DW1: [31:16] cfg_requester_id sampled at handshake; [15:8] = {3'b0, tag}; [7:4] last BE; [3:0] first BE = 4'hF.
REQ-028 Last BE = 4'h0 when req_len == 1, else 4'hF (req_len == 0 means 1024, so last BE = 4'hF).
REQ-029 3DW: DW2 = {addr[31:2], 2'b00}, DW3 = 0; 4DW: DW2 = addr[63:32], DW3 = {addr[31:2], 2'b00}.
REQ-030 Release: cpl_done_valid with busy bit set clears that bit at the next edge.
REQ-031 Release of a clear bit: bitmap unchanged; err_release = 1 the following cycle.
REQ-032 Simultaneous allocate and release, different tags: both take effect on the same edge.
REQ-033 A tag released in cycle N is not allocatable before cycle N+1; no combinational release-to-allocate bypass.
REQ-034 Release of the tag currently held in HDR is legal and clears the bit; the header is still sent.
REQ-035 tags_free is registered, equals 32 minus popcount of the bitmap after the same edge's updates.
REQ-036 Pool exhausted (tags_free = 0): req_ready = 0; no header is generated until a release occurs.

Reset
REQ-037 When rst = 1 at an edge: bitmap = 0, state = IDLE, hdr_valid = 0, hdr_data = 0, hdr_4dw = 0, err_release = 0, tags_free = 32.
REQ-038 req_ready = 0 in any cycle where rst = 1.
REQ-039 Reset during HDR discards the pending header; all tags return to free.

Verification
REQ-040 After reset, request addr 0x0000_0000_1000_0040, len 1, req id 0x0100 -> tag 0; next cycle hdr_valid, hdr_4dw = 0; DW0 = 0x0000_0001; DW1 = 0x0100_000F; DW2 = 0x1000_0040.
REQ-041 Request addr 0x0000_0001_0000_0000, len 0 -> hdr_4dw = 1; DW0 = 0x2000_0000; DW1 last/first BE = 0xFF; DW2 = 0x0000_0001; DW3 = 0.
REQ-042 32 accepted requests with hdr_ready = 1 and no releases -> tags 0..31 in order; tags_free = 0; req_ready = 0; release tag 7 -> next request gets tag 7.
REQ-043 Release of free tag 3 -> err_release pulses for 1 cycle; tags_free unchanged.
REQ-044 Hold hdr_ready = 0 for 5 cycles in HDR -> hdr_data stable and req_ready = 0 throughout; assert rst -> hdr_valid = 0 and tags_free = 32 the next cycle.
REQ-045 Same-cycle release of tag 2 and allocation of tag 5 -> both applied; tags_free unchanged at that edge.
